// File: rtl/spi_packet_master.sv
// spi_packet_master: SPI mode-0 master for the FIR filter packet link.
// Sends SAMPLES_NUM 16-bit samples followed by zero padding, and captures NBITS of
// MISO per packet.
// Optional feature: define SPI_PACKET_MASTER_SS_HOLD_EN to keep ss low between packets.
module spi_packet_master #(
    parameter int unsigned SAMPLES_NUM = 8,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SS_SETUP    = 2
) (
    input  logic                      clkIn,
    input  logic                      resetIn,
    input  logic                      startIn,
    input  logic                      abortIn,
    input  logic [16*SAMPLES_NUM-1:0] dataIn,
    output logic [32*SAMPLES_NUM-1:0] dataOut,
    output logic                      doneOut,
    output logic                      busyOut,
    output logic                      ssOut,
    output logic                      sckOut,
    output logic                      mosiOut,
    input  logic                      misoIn
);

    localparam int unsigned NBITS = 32 * SAMPLES_NUM;
    localparam int unsigned DW    = 16 * SAMPLES_NUM;
    localparam int unsigned CW    = 16;
    localparam int unsigned BW    = $clog2(NBITS);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SS_SETUP - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NBITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [BW-1:0]    bit_q;
    // Bits still to send after the one currently on mosiOut.
    logic [NBITS-2:0] tx_q;
    logic [NBITS-1:0] rx_q;

    // Packet sequencer: all outputs are registered here.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dataOut <= '0;
            doneOut <= 1'b0;
            busyOut <= 1'b0;
            ssOut   <= 1'b1;
            sckOut  <= 1'b0;
            mosiOut <= 1'b0;
        end else if (abortIn && (state_q != StIdle)) begin
            // Abort drops the frame silently; dataOut keeps the last good packet.
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            doneOut <= 1'b0;
            busyOut <= 1'b0;
            ssOut   <= 1'b1;
            sckOut  <= 1'b0;
            mosiOut <= 1'b0;
        end else begin
            doneOut <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (startIn) begin
                        tx_q    <= {dataIn[DW-2:0], {(NBITS/2){1'b0}}};
                        mosiOut <= dataIn[DW-1];
                        ssOut   <= 1'b0;
                        sckOut  <= 1'b0;
                        busyOut <= 1'b1;
                        cnt_q   <= '0;
                        bit_q   <= '0;
`ifdef SPI_PACKET_MASTER_SS_HOLD_EN
                        // Slave already selected: no setup time needed.
                        state_q <= ssOut ? StSetup : StShift;
`else
                        state_q <= StSetup;
`endif
                    end
                end
                StSetup: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StShift: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (!sckOut) begin
                            sckOut <= 1'b1;
                            rx_q   <= {rx_q[NBITS-2:0], misoIn};
                        end else begin
                            sckOut <= 1'b0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= StHold;
                            end else begin
                                bit_q   <= bit_q + 1'b1;
                                mosiOut <= tx_q[NBITS-2];
                                tx_q    <= tx_q << 1;
                            end
                        end
                    end
                end
                StHold: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= StDone;
                        doneOut <= 1'b1;
                        dataOut <= rx_q;
                        mosiOut <= 1'b0;
`ifndef SPI_PACKET_MASTER_SS_HOLD_EN
                        ssOut   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // A start seen here is ignored; it is taken in the following IDLE cycle.
                    state_q <= StIdle;
                    busyOut <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_packet_master.sv
// Scoreboard bench for spi_packet_master (SAMPLES_NUM=1 main instance, SAMPLES_NUM=2 aux).
// Follows SPI_PACKET_MASTER_SS_HOLD_EN when it is defined for the build.
module tb_spi_packet_master;

    localparam int unsigned SN = 1;
    localparam int unsigned CD = 2;
    localparam int unsigned SS = 2;
    localparam int unsigned NB = 32 * SN;
    localparam int unsigned FRAME_SHIFT = 2 * CD * NB;

    typedef struct {
        logic [31:0] data;
        int unsigned done_cyc;
        int unsigned first_rise;
        logic [31:0] mosi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, abort, miso;
    logic [15:0] din;
    logic [31:0] dout;
    logic        done, busy, ss, sck, mosi;

    logic        start2;
    logic [31:0] din2;
    logic [63:0] dout2;
    logic        done2, busy2, ss2, sck2, mosi2;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          ss_held = 1'b0;
    exp_t        exp_q[$];
    logic [127:0] exp2_q[$];

    logic [31:0] sl_word = 32'h0;
    logic [31:0] sl_sr;
    logic        sck_q;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_packet_master #(.SAMPLES_NUM(SN), .CLK_DIV(CD), .SS_SETUP(SS)) u_dut (
        .clkIn(clk), .resetIn(rst), .startIn(start), .abortIn(abort), .dataIn(din),
        .dataOut(dout), .doneOut(done), .busyOut(busy), .ssOut(ss), .sckOut(sck),
        .mosiOut(mosi), .misoIn(miso)
    );

    spi_packet_master #(.SAMPLES_NUM(2), .CLK_DIV(2), .SS_SETUP(1)) u_dut2 (
        .clkIn(clk), .resetIn(rst), .startIn(start2), .abortIn(1'b0), .dataIn(din2),
        .dataOut(dout2), .doneOut(done2), .busyOut(busy2), .ssOut(ss2), .sckOut(sck2),
        .mosiOut(mosi2), .misoIn(1'b1)
    );

    // Slave model: word loaded when a start is accepted, shifted after each sck fall.
    assign miso = sl_sr[31];
    always @(posedge clk) begin
        if (rst) sl_sr <= 32'h0;
        else if (start && !busy) sl_sr <= sl_word;
        else if (sck_q && !sck) sl_sr <= sl_sr << 1;
        sck_q <= sck;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor for the main instance.
    initial begin
        int          rises = 0;
        int          ss_low = 0;
        int unsigned first_rise = 0;
        logic [31:0] cap = 32'h0;
        logic        sp = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst || abort) begin
                rises = 0; ss_low = 0; first_rise = 0; cap = 32'h0;
            end else begin
                if (!ss) ss_low++;
                if (sck && !sp) begin
                    if (rises == 0) first_rise = cyc;
                    rises++;
                    cap = {cap[30:0], mosi};
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("data_out", dout, e.data);
                        check("done_cycle", cyc, e.done_cyc);
                        check("sck_rises", rises, NB);
                        check("mosi_bits", cap, e.mosi);
                        check("first_rise", first_rise, e.first_rise);
`ifdef SPI_PACKET_MASTER_SS_HOLD_EN
                        check("ss_at_done", ss, 0);
`else
                        check("ss_low_cycles", ss_low, 2 * SS + FRAME_SHIFT);
`endif
                    end
                    rises = 0; ss_low = 0; first_rise = 0; cap = 32'h0;
                end
            end
            sp = sck;
        end
    end

    // Monitor for the SAMPLES_NUM=2 instance.
    initial begin
        int           r2 = 0;
        logic [63:0]  cap2 = 64'h0;
        logic         sp2 = 1'b0;
        logic [127:0] e2;
        forever begin
            @(negedge clk);
            if (rst) begin
                r2 = 0; cap2 = 64'h0;
            end else begin
                if (sck2 && !sp2) begin
                    r2++;
                    cap2 = {cap2[62:0], mosi2};
                end
                if (done2) begin
                    if (exp2_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_done2: got done at cycle %0d, required none", cyc);
                    end else begin
                        e2 = exp2_q.pop_front();
                        check("d2_data_out", dout2, e2[127:64]);
                        check("d2_mosi_bits", cap2, e2[63:0]);
                        check("d2_sck_rises", r2, 64);
                    end
                    r2 = 0; cap2 = 64'h0;
                end
            end
            sp2 = sck2;
        end
    end

    // Issue one start from IDLE; optionally record the expected completion.
    task automatic issue(input logic [15:0] d, input logic [31:0] sw, input bit push);
        exp_t        e;
        int unsigned t;
        @(posedge clk); #1;
        din = d; sl_word = sw; start = 1'b1;
        t = cyc + 1;
        if (push) begin
            e.data       = sw;
            e.done_cyc   = t + (ss_held ? 0 : SS) + SS + FRAME_SHIFT;
            e.first_rise = t + (ss_held ? 0 : SS) + CD;
            e.mosi       = {d, 16'h0};
            exp_q.push_back(e);
`ifdef SPI_PACKET_MASTER_SS_HOLD_EN
            ss_held = 1'b1;
`endif
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        int   r = 0;
        int   k = 0;
        logic p;
        p = sck;
        while (r < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (sck && !p) r++;
            p = sck;
        end
        check("sck_rise_wait", r, n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || busy2) && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        check("idle_wait", {busy, busy2}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int unsigned t;
        int          nd;
        int          k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; din = 16'h0;
        start2 = 1'b0; din2 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ss", ss, 1);
        check("rst_sck", sck, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", dout, 0);

        // Reset during bit 10 of a frame.
        issue(16'hFFFF, 32'h1111_2222, 1'b0);
        wait_rises(11);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        ss_held = 1'b0;
        check("midrst_ss", ss, 1);
        check("midrst_sck", sck, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", dout, 0);

        // Clean frame after reset.
        issue(16'hA5C3, 32'hDEADBEEF, 1'b1);
        wait_idle();

        // Abort at the 5th sck rise.
        issue(16'h1234, 32'h0F0F_0F0F, 1'b0);
        wait_rises(5);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        ss_held = 1'b0;
        check("abort_ss", ss, 1);
        check("abort_sck", sck, 0);
        check("abort_mosi", mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_data", dout, 32'hDEADBEEF);
        repeat (5) @(posedge clk);

        // Start pulses and dataIn changes while busy must be ignored.
        issue(16'h5A5A, 32'hCAFE_F00D, 1'b1);
        din = 16'hFFFF;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_idle();
        repeat (10) @(posedge clk);
        #1;
        check("no_extra_frame", busy, 0);

        // Three back-to-back frames with startIn held high.
        @(posedge clk); #1;
        din = 16'h0F0F; sl_word = 32'h1357_9BDF; start = 1'b1;
        t = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            e.data       = 32'h1357_9BDF;
            e.done_cyc   = t + (ss_held ? 0 : SS) + SS + FRAME_SHIFT;
            e.first_rise = t + (ss_held ? 0 : SS) + CD;
            e.mosi       = {16'h0F0F, 16'h0};
            exp_q.push_back(e);
`ifdef SPI_PACKET_MASTER_SS_HOLD_EN
            ss_held = 1'b1;
`endif
            t = e.done_cyc + 2;
        end
        nd = 0; k = 0;
        while (nd < 3 && k < 2000) begin
            @(posedge clk); #1;
            k++;
            if (done) nd++;
        end
        start = 1'b0;
        check("b2b_done_count", nd, 3);
        wait_idle();

        // SAMPLES_NUM=2 instance, MISO tied high.
        @(posedge clk); #1;
        din2 = {16'h0001, 16'h8000}; start2 = 1'b1;
        exp2_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_8000_0000_0000});
        @(posedge clk); #1 start2 = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        check("pending_main", exp_q.size(), 0);
        check("pending_aux", exp2_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
